// File: rtl/sync_fifo_param.sv
// Single-clock parameterised FIFO with registered status flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; standard registered read otherwise.
module sync_fifo_param #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AF_TH = DEPTH - 2,
    parameter int AE_TH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_TH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_TH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty_q, full_q, af_q, ae_q;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             wr_acc, rd_acc;

    // A write into a full FIFO still succeeds when a read frees a slot on the same edge.
    always_comb begin
        wr_acc   = wr_en && (!full_q || rd_en);
        rd_acc   = rd_en && !empty_q;
        ovf_d    = wr_en && full_q && !rd_en;
        udf_d    = rd_en && empty_q;
        wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + {{(CW-1){1'b0}}, wr_acc} - {{(CW-1){1'b0}}, rd_acc};
    end

    always_comb begin
        data_out_d = data_out_q;
`ifdef SYNC_FIFO_FWFT_EN
        // Present the post-edge head; bypass data_in when the head is the word being written now.
        if (count_d != '0) begin
            data_out_d = (wr_acc && (rd_ptr_d == wr_ptr_q)) ? data_in : mem_q[rd_ptr_d];
        end
`else
        if (rd_acc) begin
            data_out_d = mem_q[rd_ptr_q];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= (count_d == '0);
            full_q     <= (count_d == DEPTH_C);
            af_q       <= (count_d >= AF_C);
            ae_q       <= (count_d <= AE_C);
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out     = data_out_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised bench for sync_fifo_param against a queue-based reference model.
// Build with SYNC_FIFO_FWFT_EN defined to exercise the fall-through output mode.
module tb_sync_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AF_TH = 14;
    localparam int AE_TH = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             wr_en = 1'b0;
    logic             rd_en = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] data_out;
    logic             empty, full, almost_full, almost_empty;
    logic [4:0]       count;
    logic             overflow, underflow;

    sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_TH(AF_TH), .AE_TH(AE_TH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
        .data_out(data_out), .empty(empty), .full(full), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_dout = '0;
    logic             exp_ovf  = 1'b0;
    logic             exp_udf  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the reference model at the edge, compare just after.
    task automatic step(input logic r, input logic w, input logic rd, input logic [WIDTH-1:0] d);
        int  sz;
        logic wacc, racc;
        logic [WIDTH-1:0] popped;
        rst = r; wr_en = w; rd_en = rd; data_in = d;
        @(posedge clk);
        if (r) begin
            q.delete();
            exp_dout = '0;
            exp_ovf  = 1'b0;
            exp_udf  = 1'b0;
        end else begin
            sz      = q.size();
            wacc    = w && ((sz < DEPTH) || rd);
            racc    = rd && (sz > 0);
            exp_ovf = w && (sz == DEPTH) && !rd;
            exp_udf = rd && (sz == 0);
            if (racc) begin
                popped = q.pop_front();
`ifndef SYNC_FIFO_FWFT_EN
                exp_dout = popped;
`endif
            end
            if (wacc) q.push_back(d);
`ifdef SYNC_FIFO_FWFT_EN
            if (q.size() > 0) exp_dout = q[0];
`endif
        end
        #1;
        chk("count",        32'(count),        32'(q.size()));
        chk("empty",        32'(empty),        32'(q.size() == 0));
        chk("full",         32'(full),         32'(q.size() == DEPTH));
        chk("almost_full",  32'(almost_full),  32'(q.size() >= AF_TH));
        chk("almost_empty", 32'(almost_empty), 32'(q.size() <= AE_TH));
        chk("overflow",     32'(overflow),     32'(exp_ovf));
        chk("underflow",    32'(underflow),    32'(exp_udf));
        chk("data_out",     32'(data_out),     32'(exp_dout));
    endtask

    initial begin
        logic [WIDTH-1:0] hold;
        int pw, pr;

        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        chk("reset_dout_zero", 32'(data_out), 32'd0);

        // Fill with 0x01..0x10, then drain in order
        for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b1, 1'b0, WIDTH'(i));
        chk("full_after_16", 32'(full), 32'd1);
        // Write to full FIFO: dropped, overflow pulses once
        step(1'b0, 1'b1, 1'b0, 8'hAA);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("ovf_one_cycle", 32'(overflow), 32'd0);
        // Simultaneous read/write while full
        step(1'b0, 1'b1, 1'b1, 8'h77);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, '0);
        chk("empty_after_drain", 32'(empty), 32'd1);

        // Read from empty: underflow, data_out held
        hold = data_out;
        step(1'b0, 1'b0, 1'b1, '0);
        chk("udf_dout_held", 32'(data_out), 32'(hold));
        step(1'b0, 1'b1, 1'b1, 8'h5C);
        chk("udf_on_rw_empty", 32'(underflow), 32'd1);
        chk("count_one", 32'(count), 32'd1);

        // Interleaved traffic holding occupancy around 7, wrapping pointers
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 1)      step(1'b0, 1'b1, 1'b0, 8'($urandom));
            else if (i % 4 == 3) step(1'b0, 1'b0, 1'b1, '0);
            else                 step(1'b0, 1'b1, 1'b1, 8'($urandom));
        end

        // Mid-operation reset with both requests active
        step(1'b0, 1'b0, 1'b1, '0);
        while (q.size() > 7) step(1'b0, 1'b0, 1'b1, '0);
        while (q.size() < 7) step(1'b0, 1'b1, 1'b0, 8'($urandom));
        step(1'b1, 1'b1, 1'b1, 8'h99);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_dout", 32'(data_out), 32'd0);

        // Fall-through / standard first-word latency from empty
        step(1'b0, 1'b1, 1'b0, 8'h3C);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, '0);
        chk("pop_to_empty", 32'(empty), 32'd1);

        // Random phases with varying bias to reach both full and empty
        for (int ph = 0; ph < 8; ph++) begin
            pw = (ph % 2 == 0) ? 80 : 20;
            pr = (ph % 2 == 0) ? 25 : 75;
            for (int i = 0; i < 60; i++) begin
                step(($urandom_range(0, 199) == 0),
                     ($urandom_range(0, 99) < pw),
                     ($urandom_range(0, 99) < pr),
                     8'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
